// File: rtl/frontend_seq.sv
// RV32I fetch/decode sequencer: FETCH latches IR, EXEC drives active-low backend controls and retires PC.
// Two cycles per instruction, no backpressure; a trap parks the block in HALT until reset.
module frontend_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic [31:0] qa,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic        load,
    output logic        store,
    output logic [31:0] alu_imm_1,
    output logic [31:0] alu_imm_2,
    output logic        alu_src_1,
    output logic        alu_src_2,
    output logic [31:0] pc,
    output logic        halt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [7:0] ALU_ADD = 8'b11111_011;
    localparam logic [7:0] ALU_SUB = 8'b11111_010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        dec_wb;
    logic        dec_load_n;
    logic        dec_store_n;
    logic [7:0]  dec_mem_op;
    logic [7:0]  dec_alu_op;
    logic        dec_src_1;
    logic        dec_src_2;
    logic [31:0] dec_imm_1;
    logic [31:0] dec_imm_2;
    logic        illegal;
    logic        taken;
    logic [31:0] next_pc;
    logic        trap;
    logic        ctrl_en;

    // bit 30 selects sub/sra; shifts and slt drive their own active-low strobe
    function automatic logic [7:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [7:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = 8'b11011_011;
            3'b010:  code = 8'b01111_010;
            3'b011:  code = 8'b10111_010;
            3'b100:  code = 8'b11111_100;
            3'b101:  code = alt ? 8'b11110_011 : 8'b11101_011;
            3'b110:  code = 8'b11111_101;
            default: code = 8'b11111_110;
        endcase
        return code;
    endfunction

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    always_comb begin
        dec_wb      = 1'b0;
        dec_load_n  = 1'b1;
        dec_store_n = 1'b1;
        dec_mem_op  = 8'hFF;
        dec_alu_op  = ALU_ADD;
        dec_src_1   = 1'b1;
        dec_src_2   = 1'b1;
        dec_imm_1   = 32'h0;
        dec_imm_2   = 32'h0;
        illegal     = 1'b0;
        taken       = 1'b0;
        next_pc     = pc_q + 32'd4;
        case (opcode)
            OPC_OP: begin
                dec_wb     = 1'b1;
                dec_alu_op = alu_code(funct3, ir_q[30]);
                illegal    = !((funct7 == 7'h00) ||
                               (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_wb     = 1'b1;
                dec_src_2  = 1'b0;
                dec_alu_op = alu_code(funct3, ir_q[30] && funct3 == 3'b101);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm_2 = {27'b0, ir_q[24:20]};
                    illegal   = !((funct7 == 7'h00) || (funct7 == 7'h20 && funct3 == 3'b101));
                end else begin
                    dec_imm_2 = imm_i;
                end
            end
            OPC_LUI: begin
                dec_wb    = 1'b1;
                dec_src_1 = 1'b0;
                dec_src_2 = 1'b0;
                dec_imm_2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_wb    = 1'b1;
                dec_src_1 = 1'b0;
                dec_src_2 = 1'b0;
                dec_imm_1 = pc_q;
                dec_imm_2 = imm_u;
            end
            OPC_JAL: begin
                dec_wb    = 1'b1;
                dec_src_1 = 1'b0;
                dec_src_2 = 1'b0;
                dec_imm_1 = pc_q;
                dec_imm_2 = 32'd4;
                next_pc   = pc_q + imm_j;
            end
            OPC_JALR: begin
                dec_wb    = 1'b1;
                dec_src_1 = 1'b0;
                dec_src_2 = 1'b0;
                dec_imm_1 = pc_q;
                dec_imm_2 = 32'd4;
                next_pc   = (qa + imm_i) & ~32'd1;
                illegal   = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                dec_wb     = 1'b1;
                dec_src_2  = 1'b0;
                dec_imm_2  = imm_i;
                dec_load_n = 1'b0;
                case (funct3)
                    3'b000:  dec_mem_op = 8'b0111_1111;
                    3'b001:  dec_mem_op = 8'b1011_1111;
                    3'b010:  dec_mem_op = 8'b1101_1111;
                    3'b100:  dec_mem_op = 8'b1110_1111;
                    3'b101:  dec_mem_op = 8'b1111_0111;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_src_2   = 1'b0;
                dec_imm_2   = imm_s;
                dec_store_n = 1'b0;
                case (funct3)
                    3'b000:  dec_mem_op = 8'b1111_1011;
                    3'b001:  dec_mem_op = 8'b1111_1101;
                    3'b010:  dec_mem_op = 8'b1111_1110;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec_alu_op = ALU_SUB;
                case (funct3)
                    3'b000:  taken   = !is_zero;
                    3'b001:  taken   = is_zero;
                    3'b100:  taken   = !is_lt;
                    3'b101:  taken   = is_lt;
                    3'b110:  taken   = !is_ltu;
                    3'b111:  taken   = is_ltu;
                    default: illegal = 1'b1;
                endcase
                if (taken) begin
                    next_pc = pc_q + imm_b;
                end
            end
            OPC_FENCE: begin
                // single in-order hart with no caches: fence retires as a nop
            end
            default: illegal = 1'b1;  // includes ECALL/EBREAK/CSR
        endcase
    end

    assign trap    = illegal || (next_pc[1:0] != 2'b00);
    assign ctrl_en = !rst && (state_q == ST_EXEC) && !trap;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (trap) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halt      = (state_q == ST_HALT);
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign rd        = ir_q[11:7];
    assign alu_imm_1 = dec_imm_1;
    assign alu_imm_2 = dec_imm_2;

    assign reg_we    = ctrl_en ? !(dec_wb && (rd != 5'd0)) : 1'b1;
    assign load      = ctrl_en ? dec_load_n  : 1'b1;
    assign store     = ctrl_en ? dec_store_n : 1'b1;
    assign mem_op    = ctrl_en ? dec_mem_op  : 8'hFF;
    assign alu_op    = ctrl_en ? dec_alu_op  : ALU_ADD;
    assign alu_src_1 = ctrl_en ? dec_src_1   : 1'b1;
    assign alu_src_2 = ctrl_en ? dec_src_2   : 1'b1;

endmodule

// File: tb/tb_frontend_seq.sv
// Directed bench for frontend_seq: a small program image steered by qa/flag inputs.
module tb_frontend_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] qa = 32'h0;
    logic        is_lt = 1'b1;
    logic        is_ltu = 1'b1;
    logic        is_zero = 1'b1;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_we, load, store, alu_src_1, alu_src_2, halt;
    logic [7:0]  alu_op, mem_op;
    logic [31:0] alu_imm_1, alu_imm_2, pc;

    logic [31:0] imem [0:127];
    int          n_checks = 0;
    int          n_errors = 0;

    assign imem_data = imem[imem_addr[8:2]];

    always #5 clk = ~clk;

    frontend_seq dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .qa        (qa),
        .is_lt     (is_lt),
        .is_ltu    (is_ltu),
        .is_zero   (is_zero),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_we    (reg_we),
        .alu_op    (alu_op),
        .mem_op    (mem_op),
        .load      (load),
        .store     (store),
        .alu_imm_1 (alu_imm_1),
        .alu_imm_2 (alu_imm_2),
        .alu_src_1 (alu_src_1),
        .alu_src_2 (alu_src_2),
        .pc        (pc),
        .halt      (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_halt", {31'b0, halt}, 32'h0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_reg_we"}, {31'b0, reg_we}, 32'h1);
        chk({tag, "_load"}, {31'b0, load}, 32'h1);
        chk({tag, "_store"}, {31'b0, store}, 32'h1);
        chk({tag, "_mem_op"}, {24'b0, mem_op}, 32'hFF);
        chk({tag, "_alu_op"}, {24'b0, alu_op}, 32'hFB);
        chk({tag, "_src"}, {30'b0, alu_src_1, alu_src_2}, 32'h3);
    endtask

    // From FETCH at 0: addi, sub, slt, lui, then beq not taken -> FETCH at 0x14
    task automatic run_to_14;
        is_zero = 1'b1;
        repeat (10) tick();
        chk("run_pc14", pc, 32'h14);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
        imem[0]   = 32'h0050_0093;  // addi x1,x0,5
        imem[1]   = 32'h4020_81B3;  // sub  x3,x1,x2
        imem[2]   = 32'h0020_A233;  // slt  x4,x1,x2
        imem[3]   = 32'h1234_5337;  // lui  x6,0x12345
        imem[4]   = 32'h0020_8463;  // beq  x1,x2,+8
        imem[5]   = 32'h0081_80E7;  // jalr x1,8(x3)
        imem[6]   = 32'hFF9F_F06F;  // jal  x0,-8
        imem[64]  = 32'h0000_C283;  // lbu  x5,0(x1)
        imem[65]  = 32'h0000_C003;  // lbu  x0,0(x1)
        imem[66]  = 32'h0020_A223;  // sw   x2,4(x1)
        imem[67]  = 32'h0000_0073;  // ecall
        imem[124] = 32'h0000_0000;  // illegal opcode

        do_reset();
        chk_idle("fetch0");
        chk("imem_addr", imem_addr, 32'h0);

        tick();
        chk("addi_rs1", {27'b0, rs1}, 32'h0);
        chk("addi_rd", {27'b0, rd}, 32'h1);
        chk("addi_src2", {31'b0, alu_src_2}, 32'h0);
        chk("addi_src1", {31'b0, alu_src_1}, 32'h1);
        chk("addi_imm2", alu_imm_2, 32'h5);
        chk("addi_we", {31'b0, reg_we}, 32'h0);
        tick();
        chk("addi_pc", pc, 32'h4);

        tick();
        chk("sub_alu", {24'b0, alu_op}, 32'hFA);
        chk("sub_src", {30'b0, alu_src_1, alu_src_2}, 32'h3);
        chk("sub_we", {31'b0, reg_we}, 32'h0);
        tick();
        tick();
        chk("slt_alu", {24'b0, alu_op}, 32'h7A);
        tick();
        tick();
        chk("lui_imm1", alu_imm_1, 32'h0);
        chk("lui_imm2", alu_imm_2, 32'h1234_5000);
        chk("lui_src", {30'b0, alu_src_1, alu_src_2}, 32'h0);
        chk("lui_alu", {24'b0, alu_op}, 32'hFB);
        tick();
        chk("pc_10", pc, 32'h10);

        is_zero = 1'b0;
        tick();
        chk("beq_t_we", {31'b0, reg_we}, 32'h1);
        chk("beq_t_alu", {24'b0, alu_op}, 32'hFA);
        tick();
        chk("beq_t_pc", pc, 32'h18);
        is_zero = 1'b1;
        tick();
        chk("jal_x0_we", {31'b0, reg_we}, 32'h1);
        chk("jal_imm1", alu_imm_1, 32'h18);
        tick();
        chk("jal_pc", pc, 32'h10);
        tick();
        chk("beq_nt_we", {31'b0, reg_we}, 32'h1);
        tick();
        chk("beq_nt_pc", pc, 32'h14);

        qa = 32'h101;
        tick();
        chk("jalr_imm1", alu_imm_1, 32'h14);
        chk("jalr_imm2", alu_imm_2, 32'h4);
        chk("jalr_we", {31'b0, reg_we}, 32'h0);
        chk("jalr_rs1", {27'b0, rs1}, 32'h3);
        tick();
        chk("jalr_pc", pc, 32'h108);

        tick();
        chk("sw_store", {31'b0, store}, 32'h0);
        chk("sw_mem_op", {24'b0, mem_op}, 32'hFE);
        chk("sw_we", {31'b0, reg_we}, 32'h1);
        chk("sw_load", {31'b0, load}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("sw_rst_store", {31'b0, store}, 32'h1);
        chk("sw_rst_mem_op", {24'b0, mem_op}, 32'hFF);
        tick();
        rst = 1'b0;
        chk("sw_rst_pc", pc, 32'h0);
        chk_idle("after_rst");

        run_to_14();
        qa = 32'hF8;
        tick();
        tick();
        chk("pc_100", pc, 32'h100);
        tick();
        chk("lbu_load", {31'b0, load}, 32'h0);
        chk("lbu_mem_op", {24'b0, mem_op}, 32'hEF);
        chk("lbu_we", {31'b0, reg_we}, 32'h0);
        chk("lbu_rd", {27'b0, rd}, 32'h5);
        tick();
        tick();
        chk("lbu_x0_we", {31'b0, reg_we}, 32'h1);
        chk("lbu_x0_load", {31'b0, load}, 32'h0);
        tick();
        tick();
        tick();
        tick();
        chk("ecall_pc", pc, 32'h10C);
        chk("ecall_we", {31'b0, reg_we}, 32'h1);
        tick();
        chk("ecall_halt", {31'b0, halt}, 32'h1);
        repeat (10) tick();
        chk("ecall_halt_hold", {31'b0, halt}, 32'h1);
        chk("ecall_pc_hold", pc, 32'h10C);
        chk_idle("halted");

        do_reset();
        run_to_14();
        qa = 32'h102;
        tick();
        chk("jalr_mis_we", {31'b0, reg_we}, 32'h1);
        tick();
        chk("jalr_mis_halt", {31'b0, halt}, 32'h1);
        chk("jalr_mis_pc", pc, 32'h14);

        do_reset();
        run_to_14();
        qa = 32'hFFFF_FFF4;
        tick();
        tick();
        chk("pc_top", pc, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("pc_wrap", pc, 32'h0);
        run_to_14();
        qa = 32'h1E8;
        tick();
        tick();
        chk("pc_1f0", pc, 32'h1F0);
        tick();
        chk("ill_we", {31'b0, reg_we}, 32'h1);
        tick();
        chk("ill_halt", {31'b0, halt}, 32'h1);
        repeat (12) tick();
        chk("ill_halt_hold", {31'b0, halt}, 32'h1);
        chk("ill_pc_hold", pc, 32'h1F0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
